// File: rtl/alu_exec_if.sv
// Start/busy/done execute-stage bus between the datapath controller and the ALU execute unit.
interface alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               Start;
    logic [3:0]         ALUControl;
    logic [WIDTH-1:0]   OperandA;
    logic [WIDTH-1:0]   OperandB;
    logic [SHAMT_W-1:0] ShiftAmount;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   Result;
    logic               Zero;
    logic               Overflow;

    modport master (
        output Start, ALUControl, OperandA, OperandB, ShiftAmount,
        input  Busy, Done, Result, Zero, Overflow
    );

    modport slave (
        input  Start, ALUControl, OperandA, OperandB, ShiftAmount,
        output Busy, Done, Result, Zero, Overflow
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: logic/add/sub in one cycle, shifts through a
// 1-bit-per-cycle iterative shifter with start/busy/done handshake.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_exec_if.slave bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;

    localparam logic [SHAMT_W-1:0] SH_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] SH_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   W_ZERO  = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        logic r;
        case (code)
            OP_SLL:  r = 1'b1;
            OP_SRL:  r = 1'b1;
            OP_SRA:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [3:0]       code);
        logic [WIDTH-1:0] r;
        case (code)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t             state_r, state_s;
    logic [SHAMT_W-1:0] count_r, count_s;
    logic [WIDTH-1:0]   shreg_r, shreg_s;
    logic [3:0]         op_r, op_s;
    logic [WIDTH-1:0]   result_r, result_s;
    logic               zero_r, zero_s;
    logic               ovf_r, ovf_s;
    logic               done_r, done_s;
    logic               busy_r, busy_s;

    logic [WIDTH-1:0]   sum_s, diff_s, alu_res_s, shifted_s;
    logic               add_ovf_s, sub_ovf_s, alu_ovf_s;

    // Single-cycle datapath; a shift code here only ever sees shamt=0, so it returns B.
    always_comb begin
        sum_s     = bus.OperandA + bus.OperandB;
        diff_s    = bus.OperandA - bus.OperandB;
        add_ovf_s = (bus.OperandA[WIDTH-1] == bus.OperandB[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != bus.OperandA[WIDTH-1]);
        sub_ovf_s = (bus.OperandA[WIDTH-1] != bus.OperandB[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != bus.OperandA[WIDTH-1]);
        alu_res_s = sum_s;
        alu_ovf_s = add_ovf_s;
        case (bus.ALUControl)
            OP_AND: begin
                alu_res_s = bus.OperandA & bus.OperandB;
                alu_ovf_s = 1'b0;
            end
            OP_OR: begin
                alu_res_s = bus.OperandA | bus.OperandB;
                alu_ovf_s = 1'b0;
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = sub_ovf_s;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res_s = bus.OperandB;
                alu_ovf_s = 1'b0;
            end
            default: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf_s;
            end
        endcase
    end

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        shreg_s   = shreg_r;
        op_s      = op_r;
        result_s  = result_r;
        zero_s    = zero_r;
        ovf_s     = ovf_r;
        done_s    = 1'b0;
        busy_s    = busy_r;
        shifted_s = shift_one(shreg_r, op_r);
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (bus.Start) begin
                    if (is_shift(bus.ALUControl) && (bus.ShiftAmount != SH_ZERO)) begin
                        shreg_s = bus.OperandB;
                        count_s = bus.ShiftAmount;
                        op_s    = bus.ALUControl;
                        state_s = ST_SHIFT;
                        busy_s  = 1'b1;
                    end else begin
                        result_s = alu_res_s;
                        zero_s   = (alu_res_s == W_ZERO);
                        ovf_s    = alu_ovf_s;
                        done_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_s = shifted_s;
                count_s = count_r - SH_ONE;
                // The last shift lands directly in Result so Done follows the n-th shift edge.
                if (count_r == SH_ONE) begin
                    result_s = shifted_s;
                    zero_s   = (shifted_s == W_ZERO);
                    ovf_s    = 1'b0;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any shift without a Done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            count_r  <= SH_ZERO;
            shreg_r  <= W_ZERO;
            op_r     <= 4'b0000;
            result_r <= W_ZERO;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            shreg_r  <= shreg_s;
            op_r     <= op_s;
            result_r <= result_s;
            zero_r   <= zero_s;
            ovf_r    <= ovf_s;
            done_r   <= done_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.Busy     = busy_r;
    assign bus.Done     = done_r;
    assign bus.Result   = result_r;
    assign bus.Zero     = zero_r;
    assign bus.Overflow = ovf_r;

endmodule
